// File: rtl/pc_ctrl_pkg.sv
// Shared PC-control encodings between the controller and the PC/return unit.
package pc_ctrl_pkg;
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_JMP = 2'b01;
    localparam logic [1:0] PC_RET = 2'b10;
    localparam logic [1:0] PC_BR  = 2'b11;

    localparam int ADDR_W_DEF = 12;
endpackage

// File: rtl/return_stack.sv
// Return-address LIFO: top entry is visible combinationally, no error logic.
// The caller guarantees that push and pop are never asserted together.
module return_stack
    import pc_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        wdata,
    output logic [ADDR_W-1:0]        top,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     empty,
    output logic                     full
);
    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [SPW-1:0]    r_sp;
    logic [IW-1:0]     w_top_idx;
    logic              w_wr;

    assign empty     = (r_sp == '0);
    assign full      = (r_sp == SPW'(DEPTH));
    assign w_wr      = push && !full;
    // Only the low bits index the RAM; an empty stack reads a don't-care entry.
    assign w_top_idx = r_sp[IW-1:0] - IW'(1);
    assign top       = r_mem[w_top_idx];
    assign sp        = r_sp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_sp <= '0;
        else if (w_wr)           r_sp <= r_sp + SPW'(1);
        else if (pop && !empty)  r_sp <= r_sp - SPW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_sp[IW-1:0]] <= wdata;
    end
endmodule

// File: rtl/pc_return_unit.sv
// Program counter with return-address stack: next-PC mux, push/pop
// qualification against pc_src, and sticky error flags.
module pc_return_unit
    import pc_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [1:0]             pc_src,
    input  logic                   stack_push,
    input  logic                   stack_pop,
    input  logic [ADDR_W-1:0]      jump_target,
    input  logic [7:0]             branch_offset,
    output logic [ADDR_W-1:0]      pc,
    output logic [ADDR_W-1:0]      pc_plus1,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   stack_empty,
    output logic                   stack_full,
    output logic                   err_overflow,
    output logic                   err_underflow,
    output logic                   err_illegal
);
    logic [ADDR_W-1:0] r_pc;
    logic              r_err_ovf, r_err_unf, r_err_ill;

    logic [ADDR_W-1:0] w_pc_next, w_br_target, w_top;
    logic              w_empty, w_full;
    logic              w_push_ctx, w_pop_ctx, w_illegal;
    logic              w_do_push, w_do_pop;

    assign w_pc_next = '0;
    assign pc_plus1    = r_pc + ADDR_W'(1);
    assign w_br_target = pc_plus1 + {{(ADDR_W-8){branch_offset[7]}}, branch_offset};

    // A push/pop is honoured only when it matches pc_src and the other is idle.
    assign w_push_ctx = stack_push && !stack_pop && (pc_src == PC_JMP);
    assign w_pop_ctx  = stack_pop && !stack_push && (pc_src == PC_RET);
    assign w_illegal  = (stack_push && pc_src != PC_JMP)
                     || (stack_pop  && pc_src != PC_RET)
                     || (stack_push && stack_pop)
                     || (pc_src == PC_RET && !stack_pop);

    assign w_do_push = !stall && w_push_ctx && !w_full;
    assign w_do_pop  = !stall && w_pop_ctx  && !w_empty;

    return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (w_do_push),
        .pop   (w_do_pop),
        .wdata (pc_plus1),
        .top   (w_top),
        .sp    (sp),
        .empty (w_empty),
        .full  (w_full)
    );

    logic [ADDR_W-1:0] w_pc_mux;
    always_comb begin
        w_pc_mux = pc_plus1;
        unique case (pc_src)
            PC_SEQ: w_pc_mux = pc_plus1;
            PC_JMP: w_pc_mux = jump_target;
            PC_RET: w_pc_mux = w_empty ? pc_plus1 : w_top;
            PC_BR:  w_pc_mux = w_br_target;
            default: w_pc_mux = pc_plus1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            r_err_ill <= 1'b0;
        end else if (!stall) begin
            r_pc <= w_pc_mux;
            if (w_push_ctx && w_full)  r_err_ovf <= 1'b1;
            if (w_pop_ctx && w_empty)  r_err_unf <= 1'b1;
            if (w_illegal)             r_err_ill <= 1'b1;
        end
    end

    assign pc            = r_pc;
    assign stack_empty   = w_empty;
    assign stack_full    = w_full;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;
    assign err_illegal   = r_err_ill;

    logic w_unused;
    assign w_unused = ^w_pc_next;
endmodule
